czpmem_loader: RTL and testbench
================================

Name: czpmem_loader

Overview:
- Byte-stream program loader; the write side of the czpmem program memory.
- Receives a length-prefixed byte stream from the host link (UART/debug bridge), packs bytes little-endian into 32-bit instruction words, and drives the program-memory write port word by word from address 0.
- Holds the core in reset (CPU_HOLD) until a complete image has been written.

Parameters:
PC_WIDTH, 10, program-memory word address width; capacity 2**PC_WIDTH words.

Ports:
CLK  in  1  system clock, all logic on rising edge
RST_N  in  1  asynchronous active-low reset
START  in  1  one-cycle pulse: begin a new load (honoured in IDLE, DONE, ERR only)
BYTE_IN  in  8  stream byte
BYTE_VLD  in  1  BYTE_IN valid
BYTE_RDY  out  1  loader accepts a byte this cycle; transfer = BYTE_VLD & BYTE_RDY
PM_WE  out  1  program-memory write enable, one-cycle pulse per word
PM_WADDR  out  PC_WIDTH  program-memory word address
PM_WDATA  out  32  program-memory write data
CPU_HOLD  out  1  core held in reset while high
BUSY  out  1  high in LEN and DATA states
DONE  out  1  high in DONE state
ERR  out  1  high in ERR state
WORD_CNT  out  PC_WIDTH+1  number of words written in the current load

Behaviour:
- Reset (async, RST_N low): state=IDLE; BYTE_RDY=0, PM_WE=0, PM_WADDR=0, PM_WDATA=0, CPU_HOLD=1, BUSY=0, DONE=0, ERR=0, WORD_CNT=0; byte index and length registers = 0. Reset mid-load aborts it; no further PM_WE.
- States: IDLE, LEN, DATA, DONE, ERR.
- IDLE: BYTE_RDY=0, CPU_HOLD=1. START -> LEN next cycle; clear WORD_CNT, PM_WADDR, byte index.
- LEN: BYTE_RDY=1. Accept 4 bytes, little-endian (1st byte -> bits 7:0), to form word count N.
  - N == 0 -> DONE.
  - N > 2**PC_WIDTH -> ERR.
  - Otherwise -> DATA.
  - Transition occurs on the cycle after the 4th transfer.
- DATA: BYTE_RDY=1 continuously, including write cycles (no back-pressure). Bytes pack little-endian into a 32-bit shift/assembly register.
  - On the 4th byte transfer of a word: register PM_WDATA=assembled word and PM_WADDR=WORD_CNT[PC_WIDTH-1:0]; PM_WE=1 in the following cycle only.
  - WORD_CNT increments in the same cycle PM_WE is high.
  - Latency: last byte of word accepted at edge k -> PM_WE high in cycle k+1.
  - A byte accepted during the PM_WE cycle starts the next word normally.
- After the write of word N-1 (WORD_CNT reaches N): BYTE_RDY drops in the cycle PM_WE is high for that word, so no extra byte is consumed; -> DONE next cycle.
- DONE: CPU_HOLD=0, DONE=1, BYTE_RDY=0. Stays until START, which re-enters LEN with CPU_HOLD=1 in the next cycle.
- ERR: CPU_HOLD=1, ERR=1, BYTE_RDY=0, no writes. Exit only via START (-> LEN) or reset.
- START while in LEN or DATA: ignored.
- BYTE_VLD while BYTE_RDY=0: byte not consumed; BYTE_IN ignored.
- Bubbles (BYTE_VLD low) anywhere: no state change and no partial-word write.
- PM_WADDR never wraps: N is bounded at ≤ 2**PC_WIDTH, and at N = 2**PC_WIDTH the last address is 2**PC_WIDTH-1.
- All outputs registered.

Test Plan:
- Reset then idle: CPU_HOLD=1, all other outputs 0; BYTE_VLD=1 with no START -> BYTE_RDY stays 0, no PM_WE.
- START, header 02 00 00 00, data 78 56 34 12 EF BE AD DE back-to-back -> PM_WE at addr 0 data 0x12345678, then addr 1 data 0xDEADBEEF, each exactly one cycle after the 4th byte; DONE=1, CPU_HOLD=0, WORD_CNT=2; a 9th byte is not accepted.
- Same stream with random BYTE_VLD gaps -> identical writes and data; PM_WE count = 2.
- Header 00 00 00 00 -> DONE with no PM_WE. Header 01 04 00 00 (N=1025, PC_WIDTH=10) -> ERR=1, CPU_HOLD=1, no PM_WE; START -> LEN again.
- Header N=1024 with 4096 data bytes -> last write at PM_WADDR=1023, WORD_CNT=1024, DONE.
- RST_N low after 6 data bytes of N=2 -> immediate reset values, no further PM_WE; START in DONE re-asserts CPU_HOLD and reloads from address 0.

Source files
------------

// File: rtl/czpmem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : czpmem_loader_if
// Description : Byte-stream and program-memory write-port bundle for the
//               czpmem loader. The master modport is the loader itself: it
//               consumes the host byte stream and drives the memory write port.
//               The slave modport is the environment: host link plus memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface czpmem_loader_if #(
  parameter int PC_WIDTH = 10
);
  logic [7:0]          BYTE_IN;
  logic                BYTE_VLD;
  logic                BYTE_RDY;
  logic                PM_WE;
  logic [PC_WIDTH-1:0] PM_WADDR;
  logic [31:0]         PM_WDATA;

  modport master (
    input  BYTE_IN, BYTE_VLD,
    output BYTE_RDY, PM_WE, PM_WADDR, PM_WDATA
  );

  modport slave (
    output BYTE_IN, BYTE_VLD,
    input  BYTE_RDY, PM_WE, PM_WADDR, PM_WDATA
  );
endinterface
`default_nettype wire

// File: rtl/czpmem_loader.sv
`default_nettype none
// ============================================================================
// Module      : czpmem_loader
// Description : Program loader. Takes a 4-byte little-endian word count N
//               followed by N little-endian 32-bit words from the host byte
//               stream and writes them to program memory from address 0,
//               holding the core in reset until the image is complete.
// Revision    : 1.0 - initial release
// ============================================================================
module czpmem_loader #(
  parameter int PC_WIDTH = 10
) (
  input  wire logic          CLK,
  input  wire logic          RST_N,
  input  wire logic          START,
  czpmem_loader_if.master    bus,
  output logic               CPU_HOLD,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR,
  output logic [PC_WIDTH:0]  WORD_CNT
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  // Largest image that fits; a header above this cannot be loaded.
  localparam logic [31:0] MAX_WORDS = 32'd1 << PC_WIDTH;

  state_t              state_q;
  logic [1:0]          idx_q;      // byte position within the current word
  logic [23:0]         asm_q;      // first three bytes of the word being built
  logic [PC_WIDTH:0]   len_q;      // validated word count N
  logic [PC_WIDTH:0]   cnt_q;
  logic                rdy_q;
  logic                we_q;
  logic [PC_WIDTH-1:0] waddr_q;
  logic [31:0]         wdata_q;
  logic                hold_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  logic                xfer;
  logic [31:0]         full_word;
  logic [PC_WIDTH:0]   cnt_inc_d;

  assign xfer      = bus.BYTE_VLD & rdy_q;
  // The 4th byte completes a word straight from the input, so no extra cycle.
  assign full_word = {bus.BYTE_IN, asm_q};
  assign cnt_inc_d = cnt_q + 1'b1;

  assign bus.BYTE_RDY = rdy_q;
  assign bus.PM_WE    = we_q;
  assign bus.PM_WADDR = waddr_q;
  assign bus.PM_WDATA = wdata_q;
  assign CPU_HOLD     = hold_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign ERR          = err_q;
  assign WORD_CNT     = cnt_q;

  // Loader FSM: header capture, word assembly, write pulses and status flags.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      asm_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (START) begin
            state_q <= S_LEN;
            idx_q   <= '0;
            asm_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            waddr_q <= '0;
            rdy_q   <= 1'b1;
            hold_q  <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end

        S_LEN: begin
          if (xfer) begin
            if (idx_q == 2'd3) begin
              idx_q <= '0;
              if (full_word == 32'd0) begin
                state_q <= S_DONE;
                rdy_q   <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                hold_q  <= 1'b0;
              end else if (full_word > MAX_WORDS) begin
                state_q <= S_ERR;
                rdy_q   <= 1'b0;
                busy_q  <= 1'b0;
                err_q   <= 1'b1;
              end else begin
                state_q <= S_DATA;
                len_q   <= full_word[PC_WIDTH:0];
              end
            end else begin
              case (idx_q)
                2'd0:    asm_q[7:0]   <= bus.BYTE_IN;
                2'd1:    asm_q[15:8]  <= bus.BYTE_IN;
                default: asm_q[23:16] <= bus.BYTE_IN;
              endcase
              idx_q <= idx_q + 2'd1;
            end
          end
        end

        S_DATA: begin
          // Ready was dropped with the final word's write pulse; finish now.
          if (!rdy_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hold_q  <= 1'b0;
          end else if (xfer) begin
            if (idx_q == 2'd3) begin
              idx_q   <= '0;
              wdata_q <= full_word;
              waddr_q <= cnt_q[PC_WIDTH-1:0];
              we_q    <= 1'b1;
              cnt_q   <= cnt_inc_d;
              if (cnt_inc_d == len_q) begin
                rdy_q <= 1'b0;
              end
            end else begin
              case (idx_q)
                2'd0:    asm_q[7:0]   <= bus.BYTE_IN;
                2'd1:    asm_q[15:8]  <= bus.BYTE_IN;
                default: asm_q[23:16] <= bus.BYTE_IN;
              endcase
              idx_q <= idx_q + 2'd1;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          rdy_q   <= 1'b0;
          hold_q  <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_czpmem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_czpmem_loader
// Description : Self-checking bench for czpmem_loader. Stimulus pushes each
//               expected memory write (address, data, cycle) into a queue; a
//               monitor pops and compares on every PM_WE.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_czpmem_loader;
  localparam int PCW = 10;

  logic           CLK = 1'b0;
  logic           RST_N;
  logic           START;
  logic           CPU_HOLD, BUSY, DONE, ERR;
  logic [PCW:0]   WORD_CNT;

  czpmem_loader_if #(.PC_WIDTH(PCW)) bus ();

  czpmem_loader #(.PC_WIDTH(PCW)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .START    (START),
    .bus      (bus),
    .CPU_HOLD (CPU_HOLD),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ERR      (ERR),
    .WORD_CNT (WORD_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [PCW-1:0] addr;
    logic [31:0]    data;
    longint         cyc;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  longint      cyc = 0;
  longint      last_edge = 0;
  int          we_cnt = 0;
  int          last_addr = -1;
  logic [31:0] data_w [0:1023];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: every PM_WE must match the oldest expected write.
  always @(negedge CLK) begin : mon
    exp_t e;
    if (RST_N === 1'b1 && bus.PM_WE === 1'b1) begin
      we_cnt++;
      last_addr = int'(bus.PM_WADDR);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                 bus.PM_WADDR, bus.PM_WDATA);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(bus.PM_WADDR), 32'(e.addr));
        chk("wr_data", bus.PM_WDATA, e.data);
        chk("wr_cycle", cyc[31:0], e.cyc[31:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) @(negedge CLK);
    @(negedge CLK);
    bus.BYTE_IN  = b;
    bus.BYTE_VLD = 1'b1;
    t = 0;
    while (bus.BYTE_RDY !== 1'b1 && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout: byte 0x%0h not accepted within 50 cycles", b);
      bus.BYTE_VLD = 1'b0;
    end else begin
      last_edge = cyc + 1;
      @(posedge CLK);
      #1;
      bus.BYTE_VLD = 1'b0;
    end
  endtask

  task automatic pick_gap(input int maxgap, output int g);
    g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
  endtask

  task automatic load_stream(input logic [31:0] n, input int nwords, input int maxgap);
    logic [31:0] w;
    int          g;
    exp_t        e;
    for (int k = 0; k < 4; k++) begin
      pick_gap(maxgap, g);
      send_byte(n[8*k +: 8], g);
    end
    for (int i = 0; i < nwords; i++) begin
      w = data_w[i];
      for (int k = 0; k < 4; k++) begin
        pick_gap(maxgap, g);
        send_byte(w[8*k +: 8], g);
        if (k == 3) begin
          e.addr = i[PCW-1:0];
          e.data = w;
          e.cyc  = last_edge;
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic do_start();
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  // sel 0 waits for DONE, sel 1 for ERR; bounded.
  task automatic wait_flag(input int sel, input string name);
    int t;
    t = 0;
    while (((sel == 0) ? DONE : ERR) !== 1'b1 && t < 200) begin
      @(negedge CLK);
      t++;
    end
    chk(name, 32'((sel == 0) ? DONE : ERR), 32'd1);
  endtask

  task automatic probe_no_accept(input string name);
    int seen;
    seen = 0;
    @(negedge CLK);
    bus.BYTE_IN  = 8'h55;
    bus.BYTE_VLD = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      if (bus.BYTE_RDY !== 1'b0) seen++;
    end
    bus.BYTE_VLD = 1'b0;
    chk(name, 32'(seen), 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] iv;
    RST_N        = 1'b0;
    START        = 1'b0;
    bus.BYTE_IN  = 8'h00;
    bus.BYTE_VLD = 1'b0;
    repeat (3) @(negedge CLK);

    // Reset values
    chk("rst_hold",  32'(CPU_HOLD), 32'd1);
    chk("rst_rdy",   32'(bus.BYTE_RDY), 32'd0);
    chk("rst_we",    32'(bus.PM_WE), 32'd0);
    chk("rst_waddr", 32'(bus.PM_WADDR), 32'd0);
    chk("rst_wdata", bus.PM_WDATA, 32'd0);
    chk("rst_flags", {29'd0, BUSY, DONE, ERR}, 32'd0);
    chk("rst_cnt",   32'(WORD_CNT), 32'd0);
    RST_N = 1'b1;
    probe_no_accept("idle_no_accept");
    chk("idle_hold", 32'(CPU_HOLD), 32'd1);

    // Two words back-to-back
    data_w[0] = 32'h12345678;
    data_w[1] = 32'hDEADBEEF;
    do_start();
    chk("len_busy", 32'(BUSY), 32'd1);
    chk("len_rdy",  32'(bus.BYTE_RDY), 32'd1);
    we_cnt = 0;
    load_stream(32'd2, 2, 0);
    wait_flag(0, "b2b_done");
    chk("b2b_hold", 32'(CPU_HOLD), 32'd0);
    chk("b2b_cnt",  32'(WORD_CNT), 32'd2);
    chk("b2b_busy", 32'(BUSY), 32'd0);
    chk("b2b_sb",   32'(sb.size()), 32'd0);
    probe_no_accept("b2b_no_9th_byte");
    chk("b2b_cnt_after", 32'(WORD_CNT), 32'd2);

    // Same stream with random bubbles
    do_start();
    we_cnt = 0;
    load_stream(32'd2, 2, 3);
    wait_flag(0, "gap_done");
    chk("gap_we_count", 32'(we_cnt), 32'd2);
    chk("gap_cnt", 32'(WORD_CNT), 32'd2);
    chk("gap_sb",  32'(sb.size()), 32'd0);

    // Empty image
    do_start();
    we_cnt = 0;
    load_stream(32'd0, 0, 0);
    wait_flag(0, "zero_done");
    chk("zero_cnt",  32'(WORD_CNT), 32'd0);
    chk("zero_we",   32'(we_cnt), 32'd0);
    chk("zero_hold", 32'(CPU_HOLD), 32'd0);

    // Oversized image: N = 1025
    do_start();
    load_stream(32'h0000_0401, 0, 0);
    wait_flag(1, "big_err");
    chk("err_hold", 32'(CPU_HOLD), 32'd1);
    chk("err_done", 32'(DONE), 32'd0);
    probe_no_accept("err_no_accept");
    do_start();
    chk("err_restart_busy", 32'(BUSY), 32'd1);
    chk("err_restart_err",  32'(ERR), 32'd0);

    // Full-capacity image: N = 1024, already in LEN
    for (int i = 0; i < 1024; i++) begin
      iv = i;
      data_w[i] = {iv[15:0] ^ 16'hA5A5, iv[15:0]};
    end
    we_cnt = 0;
    load_stream(32'd1024, 1024, 0);
    wait_flag(0, "full_done");
    chk("full_cnt",       32'(WORD_CNT), 32'd1024);
    chk("full_last_addr", 32'(last_addr), 32'd1023);
    chk("full_we_count",  32'(we_cnt), 32'd1024);
    chk("full_sb",        32'(sb.size()), 32'd0);

    // Reset in the middle of the second word
    data_w[0] = 32'h12345678;
    data_w[1] = 32'hDEADBEEF;
    do_start();
    load_stream(32'd2, 1, 0);
    send_byte(8'hEF, 0);
    send_byte(8'hBE, 0);
    @(negedge CLK);
    chk("mid_cnt_before", 32'(WORD_CNT), 32'd1);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_hold", 32'(CPU_HOLD), 32'd1);
    chk("mid_rst_busy", 32'(BUSY), 32'd0);
    chk("mid_rst_cnt",  32'(WORD_CNT), 32'd0);
    chk("mid_rst_rdy",  32'(bus.BYTE_RDY), 32'd0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    probe_no_accept("mid_idle_no_accept");
    chk("mid_sb", 32'(sb.size()), 32'd0);

    // DONE -> START reloads from address 0 with the core held again
    data_w[0] = 32'hCAFEF00D;
    do_start();
    load_stream(32'd1, 1, 0);
    wait_flag(0, "one_done");
    chk("one_hold", 32'(CPU_HOLD), 32'd0);
    do_start();
    chk("reload_hold", 32'(CPU_HOLD), 32'd1);
    chk("reload_done", 32'(DONE), 32'd0);
    data_w[0] = 32'h0BADC0DE;
    data_w[1] = 32'h00C0FFEE;
    load_stream(32'd2, 2, 1);
    wait_flag(0, "reload_done2");
    chk("reload_cnt", 32'(WORD_CNT), 32'd2);
    chk("reload_sb",  32'(sb.size()), 32'd0);

    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
